fu_rand_arbiter: RTL and testbench

Shares one multi-cycle functional unit between four reservation-station requesters in the out-of-order core. Each arbitration uses the 2-bit LFSR output as the starting point of a rotating-priority search. The winner gets a one-cycle grant pulse and owns the unit until the unit signals completion. An optional starvation guard overrides the random choice for requesters that keep losing.

---
 rtl/fu_arb_pkg.sv | 14 +
 rtl/rot_pick4.sv | 29 ++
 rtl/fu_rand_arbiter.sv | 105 ++++++++++
 tb/tb_fu_rand_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fu_arb_pkg.sv
// Shared types and constants for the random-start functional-unit arbiter.
package fu_arb_pkg;

  localparam int NREQ   = 4;
  localparam int IDX_W  = 2;
  localparam int WAIT_W = 4;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rot_pick4.sv
// Rotating-priority picker: first set request bit at or after the start index, wrapping mod 4.
module rot_pick4
  import fu_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = start + IDX_W'(k);
      if (!found && req[idx]) begin
        win_idx = idx;
        found   = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fu_rand_arbiter.sv
// Four-way arbiter for one multi-cycle unit; random start, ownership until fu_done.
// Optional starvation guard enabled by defining FU_ARB_STARVE_GUARD_EN.
module fu_rand_arbiter
  import fu_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rand_in,
  input  logic [NREQ-1:0]  req,
  input  logic             fu_done,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] owner,
  output logic             unit_busy
);

  localparam logic [WAIT_W-1:0] LIMIT4 = WAIT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] pick_idx, win;
  logic             any_req, arb_fire;

  rot_pick4 u_pick (
    .req     (req),
    .start   (rand_in),
    .win_idx (pick_idx),
    .any     (any_req)
  );

`ifdef FU_ARB_STARVE_GUARD_EN
  logic [WAIT_W-1:0] cnt_q [NREQ];
  logic              starve_hit;
  logic [IDX_W-1:0]  starve_idx;

  // Lowest-index starving requester overrides the random pick.
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (cnt_q[i] >= LIMIT4)) begin
        starve_hit = 1'b1;
        starve_idx = IDX_W'(i);
      end
    end
  end

  assign win = starve_hit ? starve_idx : pick_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (arb_fire) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || (IDX_W'(i) == win)) cnt_q[i] <= '0;
        else if (cnt_q[i] != '1)           cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end
`else
  logic unused_limit;
  assign unused_limit = ^LIMIT4;
  assign win = pick_idx;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    owner_d  = owner_q;
    arb_fire = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          arb_fire = 1'b1;
          state_d  = ARB_BUSY;
          gnt_d    = onehot(win);
          owner_d  = win;
        end
      end
      ARB_BUSY: begin
        if (fu_done) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign unit_busy = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_fu_rand_arbiter.sv
// Directed-vector bench for fu_rand_arbiter; guard scenarios run when FU_ARB_STARVE_GUARD_EN is defined.
module tb_fu_rand_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rand_in;
  logic [3:0] req;
  logic       fu_done;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       unit_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fu_rand_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rand_in   (rand_in),
    .req       (req),
    .fu_done   (fu_done),
    .gnt       (gnt),
    .owner     (owner),
    .unit_busy (unit_busy)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; fu_done = 1'b0; rand_in = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic release_unit();
    fu_done = 1'b1;
    step();
    fu_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; fu_done = 1'b0; rand_in = '0;
    #1;

    // Reset and idle with no requests
    do_reset();
    check_eq("rst_gnt", 8'(gnt), 8'h0);
    check_eq("rst_owner", 8'(owner), 8'h0);
    check_eq("rst_busy", 8'(unit_busy), 8'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("idle_gnt", 8'(gnt), 8'h0);
      check_eq("idle_owner", 8'(owner), 8'h0);
      check_eq("idle_busy", 8'(unit_busy), 8'h0);
    end

    // Rotating start: req=1010
    req = 4'b1010; rand_in = 2'd0;
    step();
    check_eq("r0_gnt", 8'(gnt), 8'h02);
    check_eq("r0_owner", 8'(owner), 8'h1);
    check_eq("r0_busy", 8'(unit_busy), 8'h1);
    req = '0; rand_in = 2'd3;
    step();
    check_eq("r0_pulse", 8'(gnt), 8'h0);
    release_unit();
    check_eq("r0_rel_busy", 8'(unit_busy), 8'h0);
    check_eq("r0_owner_hold", 8'(owner), 8'h1);
    req = 4'b1010; rand_in = 2'd2;
    step();
    check_eq("r2_gnt", 8'(gnt), 8'h08);
    check_eq("r2_owner", 8'(owner), 8'h3);
    req = '0;
    release_unit();

    // Ownership held with no fu_done, then release and re-grant
    do_reset();
    req = 4'b1111; rand_in = 2'd0;
    step();
    check_eq("hold_gnt", 8'(gnt), 8'h01);
    check_eq("hold_owner", 8'(owner), 8'h0);
    for (int i = 0; i < 20; i++) begin
      rand_in = 2'(i);
      step();
      check_eq("hold_nognt", 8'(gnt), 8'h0);
      check_eq("hold_busy", 8'(unit_busy), 8'h1);
    end
    rand_in = 2'd2;
    release_unit();
    check_eq("rel_busy", 8'(unit_busy), 8'h0);
    check_eq("rel_gnt", 8'(gnt), 8'h0);
    step();
    check_eq("next_gnt", 8'(gnt), 8'h04);
    check_eq("next_owner", 8'(owner), 8'h2);
    check_eq("next_busy", 8'(unit_busy), 8'h1);
    step();
    check_eq("next_pulse", 8'(gnt), 8'h0);

    // Reset while busy, stray fu_done, then re-grant
    do_reset();
    req = 4'b0100; rand_in = 2'd0;
    step();
    check_eq("rb_gnt", 8'(gnt), 8'h04);
    step();
    check_eq("rb_busy", 8'(unit_busy), 8'h1);
    reset = 1'b1;
    step();
    reset = 1'b0; req = '0;
    check_eq("rb_busy_clr", 8'(unit_busy), 8'h0);
    check_eq("rb_owner_clr", 8'(owner), 8'h0);
    check_eq("rb_gnt_clr", 8'(gnt), 8'h0);
    fu_done = 1'b1;
    step();
    fu_done = 1'b0;
    check_eq("stray_busy", 8'(unit_busy), 8'h0);
    check_eq("stray_gnt", 8'(gnt), 8'h0);
    req = 4'b0100; rand_in = 2'd3;
    step();
    check_eq("rb_regnt", 8'(gnt), 8'h04);
    check_eq("rb_reowner", 8'(owner), 8'h2);
    req = '0;
    release_unit();

`ifdef FU_ARB_STARVE_GUARD_EN
    // Forced win after two losses (limit 2)
    do_reset();
    req = 4'b0011; rand_in = 2'd1;
    step();
    check_eq("sg_a1", 8'(gnt), 8'h02);
    release_unit();
    step();
    check_eq("sg_a2", 8'(gnt), 8'h02);
    release_unit();
    step();
    check_eq("sg_a3_forced", 8'(gnt), 8'h01);
    check_eq("sg_a3_owner", 8'(owner), 8'h0);
    release_unit();
    step();
    check_eq("sg_a4_cleared", 8'(gnt), 8'h02);
    req = '0;
    release_unit();

    // Dropping req clears the wait counter
    do_reset();
    req = 4'b0011; rand_in = 2'd1;
    step();
    check_eq("sd_a1", 8'(gnt), 8'h02);
    req = 4'b0010;
    release_unit();
    step();
    check_eq("sd_a2", 8'(gnt), 8'h02);
    req = 4'b0011;
    release_unit();
    step();
    check_eq("sd_a3", 8'(gnt), 8'h02);
    release_unit();
    step();
    check_eq("sd_a4_noforce", 8'(gnt), 8'h02);
    req = '0;
    release_unit();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
